vga_sync_monitor: RTL and testbench

Receive-side counterpart of the VGA timing generator: samples an incoming h_sync/v_sync pair, measures line period, sync widths and frame height, and regenerates x/y position counters. Sits on a video input path, or loops back on our own VGA outputs for self-check. Declares lock once the measured timing is stable for a programmable number of frames, and flags lock loss.

---
 rtl/vga_sync_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// VGA sync receiver: measures line/frame timing, regenerates x/y and tracks lock.
// Define VGA_SYNC_MON_SYNC_EN to add a two-flop synchronizer on h_sync/v_sync.
module vga_sync_monitor #(
    parameter int unsigned H_W         = 10,
    parameter int unsigned V_W         = 10,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           h_sync,
    input  logic           v_sync,
    input  logic           h_pol,
    input  logic           v_pol,
    output logic [H_W-1:0] h_total,
    output logic [H_W-1:0] h_sync_width,
    output logic [V_W-1:0] v_total,
    output logic [V_W-1:0] v_sync_width,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           frame_start,
    output logic           locked,
    output logic           lock_lost
);

    localparam int unsigned    M_W   = 4;
    localparam logic [H_W-1:0] H_MAX = '1;
    localparam logic [V_W-1:0] V_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t         state;
    logic           h_in, v_in;
    logic           hs_q, hs_q2, vs_q, vs_line;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] vs_cnt;
    logic [H_W-1:0] ref_h_total, ref_h_sw;
    logic [V_W-1:0] ref_v_total, ref_v_sw;
    logic           ref_valid, h_unstable, locked_d;
    logic [M_W-1:0] match_cnt;

`ifdef VGA_SYNC_MON_SYNC_EN
    logic [1:0] h_meta, v_meta;

    // Two-flop synchronizer for sources not timed to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_meta <= '0;
            v_meta <= '0;
        end else begin
            h_meta <= {h_meta[0], h_sync};
            v_meta <= {v_meta[0], v_sync};
        end
    end

    assign h_in = h_meta[1];
    assign v_in = v_meta[1];
`else
    assign h_in = h_sync;
    assign v_in = v_sync;
`endif

    // Polarity-normalised sync sampling and edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q  <= 1'b0;
            hs_q2 <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            hs_q  <= (h_in == h_pol);
            hs_q2 <= hs_q;
            vs_q  <= (v_in == v_pol);
        end
    end

    logic           hs_rise, hs_fall, fs_evt, timeout, ref_eq, h_mis;
    logic [H_W-1:0] h_total_nx;
    logic [V_W-1:0] y_inc;
    logic [M_W-1:0] match_nx;

    assign hs_rise    = hs_q & ~hs_q2;
    assign hs_fall    = ~hs_q & hs_q2;
    assign h_total_nx = h_cnt + H_W'(1);
    assign y_inc      = y + V_W'(1);
    assign match_nx   = match_cnt + M_W'(1);
    assign fs_evt     = hs_rise & vs_q & ~vs_line;
    // Fires once, on the cycle h_cnt steps into saturation; a rise always wins.
    assign timeout    = ~hs_rise & (h_cnt == H_MAX - H_W'(1));
    assign ref_eq     = (h_total_nx == ref_h_total) && (h_sync_width == ref_h_sw) &&
                        (y_inc == ref_v_total) && (v_sync_width == ref_v_sw);
    assign h_mis      = hs_rise & ref_valid & (state != SEARCH) &
                        (h_total_nx != ref_h_total);
    assign x          = h_cnt;

    // Horizontal/vertical counters and measurement capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt        <= '0;
            y            <= '0;
            h_total      <= '0;
            h_sync_width <= '0;
            v_total      <= '0;
            v_sync_width <= '0;
            vs_line      <= 1'b0;
            vs_cnt       <= '0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= fs_evt;
            if (hs_rise) begin
                h_cnt <= '0;
            end else if (h_cnt != H_MAX) begin
                h_cnt <= h_total_nx;
            end
            if (hs_fall) begin
                h_sync_width <= h_total_nx;
            end
            if (hs_rise) begin
                h_total <= h_total_nx;
                vs_line <= vs_q;
                if (fs_evt) begin
                    v_total <= y_inc;
                    y       <= '0;
                end else if (y != V_MAX) begin
                    y <= y_inc;
                end
                if (vs_q) begin
                    if (!vs_line) begin
                        vs_cnt <= V_W'(1);
                    end else if (vs_cnt != V_MAX) begin
                        vs_cnt <= vs_cnt + V_W'(1);
                    end
                end else if (vs_line) begin
                    v_sync_width <= vs_cnt;
                    vs_cnt       <= '0;
                end
            end
        end
    end

    // Lock FSM: reference capture, frame matching and lock loss detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            ref_valid   <= 1'b0;
            match_cnt   <= '0;
            h_unstable  <= 1'b0;
            ref_h_total <= '0;
            ref_h_sw    <= '0;
            ref_v_total <= '0;
            ref_v_sw    <= '0;
            locked      <= 1'b0;
            locked_d    <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            locked_d  <= locked;
            lock_lost <= locked_d & ~locked;
            if (fs_evt) begin
                h_unstable <= 1'b0;
            end else if (h_mis) begin
                h_unstable <= 1'b1;
            end
            if (timeout) begin
                state      <= SEARCH;
                locked     <= 1'b0;
                ref_valid  <= 1'b0;
                match_cnt  <= '0;
                h_unstable <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (fs_evt) begin
                            state     <= MEASURE;
                            ref_valid <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    MEASURE: begin
                        if (fs_evt) begin
                            if (ref_valid && ref_eq && !h_unstable) begin
                                match_cnt <= match_nx;
                                if (match_nx == M_W'(LOCK_FRAMES)) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                ref_h_total <= h_total_nx;
                                ref_h_sw    <= h_sync_width;
                                ref_v_total <= y_inc;
                                ref_v_sw    <= v_sync_width;
                                ref_valid   <= 1'b1;
                                match_cnt   <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (fs_evt ? !(ref_eq && !h_unstable) : h_mis) begin
                            state       <= MEASURE;
                            locked      <= 1'b0;
                            match_cnt   <= '0;
                            h_unstable  <= 1'b0;
                            ref_h_total <= h_total_nx;
                            ref_h_sw    <= h_sync_width;
                            // Mid-frame reload keeps the last completed frame height.
                            ref_v_total <= fs_evt ? y_inc : v_total;
                            ref_v_sw    <= v_sync_width;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Self-checking bench for vga_sync_monitor: line/frame stimulus with a
// frame-start scoreboard plus per-scenario inline checks.
module tb_vga_sync_monitor;

    localparam int unsigned H_W = 10;
    localparam int unsigned V_W = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           h_sync = 1'b0;
    logic           v_sync = 1'b0;
    logic           h_pol = 1'b1;
    logic           v_pol = 1'b1;
    logic [H_W-1:0] h_total, h_sync_width, x;
    logic [V_W-1:0] v_total, v_sync_width, y;
    logic           frame_start, locked, lock_lost;

    vga_sync_monitor #(.H_W(H_W), .V_W(V_W), .LOCK_FRAMES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .h_pol        (h_pol),
        .v_pol        (v_pol),
        .h_total      (h_total),
        .h_sync_width (h_sync_width),
        .v_total      (v_total),
        .v_sync_width (v_sync_width),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .locked       (locked),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        int ht;
        int hw;
        int vt;
        int vw;
        bit lk;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   lost_cnt = 0;
    int   last_period = 0;
    int   last_width = 0;
    int   last_lines = 0;
    int   last_vs = 0;
    bit   prev_full = 1'b0;

    // One clock: observe outputs at the falling edge, score frame starts, then drive.
    task automatic step(input bit hs, input bit vs);
        exp_t e;
        @(negedge clk);
        if (lock_lost === 1'b1) lost_cnt++;
        if (frame_start === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fs_unexpected: frame_start seen, none expected");
            end else begin
                e = exp_q.pop_front();
                if (locked !== e.lk) begin
                    n_err++;
                    $display("FAIL fs_locked: got %0b, want %0b", locked, e.lk);
                end
                if (e.chk) begin
                    n_cmp++;
                    if (h_total !== H_W'(e.ht)) begin
                        n_err++;
                        $display("FAIL fs_h_total: got %0d, want %0d", h_total, e.ht);
                    end
                    n_cmp++;
                    if (h_sync_width !== H_W'(e.hw)) begin
                        n_err++;
                        $display("FAIL fs_h_sync_width: got %0d, want %0d", h_sync_width, e.hw);
                    end
                    n_cmp++;
                    if (v_total !== V_W'(e.vt)) begin
                        n_err++;
                        $display("FAIL fs_v_total: got %0d, want %0d", v_total, e.vt);
                    end
                    n_cmp++;
                    if (v_sync_width !== V_W'(e.vw)) begin
                        n_err++;
                        $display("FAIL fs_v_sync_width: got %0d, want %0d", v_sync_width, e.vw);
                    end
                end
            end
        end
        h_sync = hs ? h_pol : ~h_pol;
        v_sync = vs ? v_pol : ~v_pol;
    endtask

    task automatic send_line(input int period, input int width, input bit vs);
        for (int i = 0; i < period; i++) step(i < width, vs);
        last_period = period;
        last_width  = width;
    endtask

    // Expected frame-start values are those of the line/frame that just ended.
    task automatic send_frame(input int lines, input int vsl, input int period,
                              input int width, input bit lk,
                              input int sline, input int sper);
        exp_q.push_back('{prev_full, last_period, last_width, last_lines, last_vs, lk});
        for (int l = 0; l < lines; l++) send_line((l == sline) ? sper : period, width, l < vsl);
        last_lines = lines;
        last_vs    = vsl;
        prev_full  = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] act [9];
        string       nm  [9];
        nm = '{"h_total", "h_sync_width", "v_total", "v_sync_width", "x", "y",
               "frame_start", "locked", "lock_lost"};
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        @(negedge clk);
        act = '{32'(h_total), 32'(h_sync_width), 32'(v_total), 32'(v_sync_width),
                32'(x), 32'(y), 32'(frame_start), 32'(locked), 32'(lock_lost)};
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (act[i] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_%s: got %0d, want 0", nm[i], act[i]);
            end
        end
        reset     = 1'b0;
        prev_full = 1'b0;
    endtask

    task automatic test_lock();
        for (int f = 0; f < 5; f++) send_frame(9, 2, 277, 18, f >= 3, -1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL lock_locked: got %0b, want 1", locked);
        end
        n_cmp++;
        if (lost_cnt !== 0) begin
            n_err++;
            $display("FAIL lock_no_loss: got %0d lock_lost pulses, want 0", lost_cnt);
        end
    endtask

    task automatic test_stretch();
        int base;
        base = lost_cnt;
        send_frame(9, 2, 277, 18, 1'b1, 4, 280);
        n_cmp++;
        if (lost_cnt !== base + 1) begin
            n_err++;
            $display("FAIL stretch_lock_lost: got %0d pulses, want 1", lost_cnt - base);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL stretch_unlocked: got %0b, want 0", locked);
        end
        send_frame(9, 2, 277, 18, 1'b0, -1, 0);
        send_frame(9, 2, 277, 18, 1'b0, -1, 0);
        send_frame(9, 2, 277, 18, 1'b1, -1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL stretch_relock: got %0b, want 1", locked);
        end
    endtask

    task automatic test_timeout();
        int             base;
        logic [H_W-1:0] xmax;
        xmax = '1;
        base = lost_cnt;
        repeat (1100) step(1'b0, 1'b0);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_locked: got %0b, want 0", locked);
        end
        n_cmp++;
        if (lost_cnt !== base + 1) begin
            n_err++;
            $display("FAIL timeout_lock_lost: got %0d pulses, want 1", lost_cnt - base);
        end
        n_cmp++;
        if (x !== xmax) begin
            n_err++;
            $display("FAIL timeout_x_sat: got %0d, want %0d", x, xmax);
        end
        // Back in SEARCH: four frame starts are needed again.
        prev_full = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(9, 2, 120, 18, f == 3, -1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_relock: got %0b, want 1", locked);
        end
    endtask

    task automatic test_reset_locked();
        int          base;
        logic [31:0] act [9];
        base = lost_cnt;
        exp_q.push_back('{prev_full, last_period, last_width, last_lines, last_vs, 1'b1});
        for (int l = 0; l < 4; l++) send_line(120, 18, l < 2);
        for (int i = 0; i < 40; i++) step(i < 18, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        @(negedge clk);
        act = '{32'(h_total), 32'(h_sync_width), 32'(v_total), 32'(v_sync_width),
                32'(x), 32'(y), 32'(frame_start), 32'(locked), 32'(lock_lost)};
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (act[i] !== 32'd0) begin
                n_err++;
                $display("FAIL midreset_out%0d: got %0d, want 0", i, act[i]);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 78; i++) step(1'b0, 1'b0);
        for (int l = 5; l < 9; l++) send_line(120, 18, 1'b0);
        prev_full = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(9, 2, 120, 18, f == 3, -1, 0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_relock: got %0b, want 1", locked);
        end
        n_cmp++;
        if (lost_cnt !== base) begin
            n_err++;
            $display("FAIL midreset_no_loss: got %0d pulses, want 0", lost_cnt - base);
        end
    endtask

    task automatic test_polarity();
        h_pol = 1'b0;
        v_pol = 1'b0;
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        reset     = 1'b0;
        prev_full = 1'b0;
        send_frame(9, 2, 120, 18, 1'b0, -1, 0);
        send_frame(9, 2, 120, 18, 1'b0, -1, 0);
        n_cmp++;
        if (h_sync_width !== H_W'(18)) begin
            n_err++;
            $display("FAIL pol_h_sync_width: got %0d, want 18", h_sync_width);
        end
        n_cmp++;
        if (h_total !== H_W'(120)) begin
            n_err++;
            $display("FAIL pol_h_total: got %0d, want 120", h_total);
        end
    endtask

    task automatic test_alternate();
        int base;
        base = lost_cnt;
        for (int f = 0; f < 6; f++) send_frame((f % 2 == 0) ? 10 : 9, 2, 120, 18, 1'b0, -1, 0);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL alt_never_locked: got %0b, want 0", locked);
        end
        n_cmp++;
        if (lost_cnt !== base) begin
            n_err++;
            $display("FAIL alt_no_loss: got %0d pulses, want 0", lost_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_timeout();
        test_reset_locked();
        test_polarity();
        test_alternate();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fs_missing: got %0d unmatched expected frame starts, want 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
